// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port, synchronous-read framebuffer RAM between the
//   display refresh path and a CPU. Display fetches always win; the CPU
//   takes every remaining RAM cycle through a req/ack handshake.
//
// Ports
//   px_clk, rst          pixel clock, synchronous active-high reset
//   disp_active          current pixel is in the visible region
//   line_start           pulse ahead of a visible line (v_addr valid from here)
//   h_addr, v_addr       active-region column / line from the sync generator
//   disp_word(_valid)    fetched display word and its one-cycle update pulse
//   cpu_req/we/addr/wdata  CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata   one-cycle completion pulse and read data
//   mem_addr/we/wdata    RAM command, driven combinationally in the issue cycle
//   mem_rdata            RAM read data, one cycle after the address
module vga_fb_arbiter #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 80,
  parameter int PREFETCH_SLOT  = 8
) (
  input  logic              px_clk,
  input  logic              rst,
  input  logic              disp_active,
  input  logic              line_start,
  input  logic [11:0]       h_addr,
  input  logic [10:0]       v_addr,
  output logic [DATA_W-1:0] disp_word,
  output logic              disp_word_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {ST_IDLE, ST_CPU_WAIT} cpu_state_t;

  cpu_state_t        r_state;
  cpu_state_t        w_state_nxt;
  logic              r_first_pend;
  logic              r_disp_pend;
  logic              r_cpu_we;
  logic [DATA_W-1:0] r_disp_word;

  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_word_idx;
  logic [ADDR_W-1:0] w_pf_addr;
  logic              w_prefetch;
  logic              w_issue_first;
  logic              w_issue_pf;
  logic              w_issue_disp;
  logic              w_issue_cpu;
  logic              w_disp_block;

  assign w_base     = ADDR_W'(v_addr) * ADDR_W'(WORDS_PER_LINE);
  assign w_word_idx = ADDR_W'(h_addr[11:4]);
  assign w_pf_addr  = w_base + w_word_idx + ADDR_W'(1);

  assign w_prefetch = !rst && disp_active
                      && (h_addr[3:0] == 4'(PREFETCH_SLOT))
                      && (w_word_idx < ADDR_W'(WORDS_PER_LINE - 1));

  assign w_issue_first = !rst && r_first_pend;
  assign w_issue_pf    = w_prefetch && !r_first_pend;
  assign w_issue_disp  = w_issue_first || w_issue_pf;

  // line_start itself already holds the CPU off, so the first-word fetch
  // (issued the following cycle) is never delayed by a CPU access.
  assign w_disp_block = line_start || r_first_pend || w_prefetch;

  always_comb begin
    w_state_nxt = r_state;
    w_issue_cpu = 1'b0;
    cpu_ack     = 1'b0;
    cpu_rdata   = '0;
    case (r_state)
      ST_IDLE: begin
        if (!rst && cpu_req && !w_disp_block) begin
          w_issue_cpu = 1'b1;
          w_state_nxt = ST_CPU_WAIT;
        end
      end
      ST_CPU_WAIT: begin
        // Never issue here: cpu_req is still held for the request being acked.
        if (!rst) begin
          cpu_ack   = 1'b1;
          cpu_rdata = r_cpu_we ? '0 : mem_rdata;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_issue_first) begin
      mem_addr = w_base;
    end else if (w_issue_pf) begin
      mem_addr = w_pf_addr;
    end else if (w_issue_cpu) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_first_pend <= 1'b0;
      r_disp_pend  <= 1'b0;
      r_cpu_we     <= 1'b0;
      r_disp_word  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_disp_pend <= w_issue_disp;
      if (line_start) begin
        r_first_pend <= 1'b1;
      end else if (w_issue_first) begin
        r_first_pend <= 1'b0;
      end
      if (w_issue_cpu) begin
        r_cpu_we <= cpu_we;
      end
      if (r_disp_pend) begin
        r_disp_word <= mem_rdata;
      end
    end
  end

  // The RAM word is presented straight through in the return cycle and held
  // in r_disp_word afterwards, so disp_word is stable between pulses.
  assign disp_word_valid = r_disp_pend && !rst;
  assign disp_word       = rst ? '0 : (r_disp_pend ? mem_rdata : r_disp_word);

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Arbitrates one single-port, synchronous-read framebuffer RAM between two requesters: display refresh fetches and CPU read/write accesses.
- Display side is driven by the VGA sync generator outputs (h_addr, v_addr) plus an active flag and a line-start pulse.
- Each fetched 16-bit word (16 pixels, 1 bpp) is handed to the downstream pixel shifter one word ahead of use.
- Display fetches always win; the CPU uses all remaining RAM cycles through a req/ack handshake.

Parameters:
- ADDR_W, 17, framebuffer word-address width (1280*1024/16 = 81920 words).
- DATA_W, 16, framebuffer word width; one word = 16 pixels.
- WORDS_PER_LINE, 80, words per active line.
- PREFETCH_SLOT, 8, h_addr[3:0] value at which the next word of the line is fetched (0..13).

Ports:
- px_clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- disp_active  in  1  high while the current pixel is in the visible region
- line_start  in  1  one-cycle pulse at least 3 cycles before the first active pixel of a visible line; v_addr is valid and stable from this pulse through that line
- h_addr  in  12  active-region pixel column from the sync generator
- v_addr  in  11  active-region line index from the sync generator
- disp_word  out  DATA_W  fetched display word
- disp_word_valid  out  1  one-cycle pulse when disp_word is updated
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack = 1
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after the address

Behaviour:
- Reset: every output is 0, no access is outstanding, and any pending first-word request is cleared. A reset during an outstanding access drops it: no cpu_ack and no disp_word_valid follow.
- Line base: base = v_addr * WORDS_PER_LINE, computed at full ADDR_W width. Maximum address is 1023*80 + 79 = 81919, so no wrap occurs.

Display requests:
- First-word request: set by line_start; issue address base + 0.
- Prefetch: issued when disp_active = 1, h_addr[3:0] == PREFETCH_SLOT, and (h_addr >> 4) < WORDS_PER_LINE - 1. Address is base + (h_addr >> 4) + 1.
- Priority: a pending first-word request is issued ahead of the CPU in the next free cycle. A prefetch is issued in the cycle its condition holds. The two cannot coincide, because line_start occurs during blanking.

Issue cycle:
- Exactly one access is issued per cycle, with mem_addr, mem_we and mem_wdata driven combinationally from the arbitration result.
- Priority order: display request > CPU.

CPU handshake, modelled as states IDLE and CPU_WAIT:
- IDLE: if cpu_req = 1 and no display request is present this cycle, issue the CPU access, capture cpu_we, and go to CPU_WAIT. If a display request is present, stay in IDLE; the CPU is retried next cycle.
- CPU_WAIT (the cycle after issue): assert cpu_ack. For a read, cpu_rdata = mem_rdata. For a write, cpu_rdata = 0. Return to IDLE. No CPU access is issued in this cycle, which avoids re-issuing the still-held request.
- Display requests may be issued while in CPU_WAIT.
- Maximum CPU wait is 1 cycle when a prefetch collides, and 2 cycles when the collision is with a pending first-word fetch.

Display return:
- One cycle after a display issue, register disp_word = mem_rdata and pulse disp_word_valid.
- The downstream shifter loads the word at the next h_addr[3:0] == 15 boundary (outside this block).

Other rules:
- mem_we is 0 on every display cycle and every idle cycle.
- When disp_active = 0 (outside the visible region), all RAM cycles are available to the CPU except the single first-word fetch.

Test Plan:
- Reset, then line_start with v_addr = 5 and cpu_req = 0 → next cycle mem_addr = 400, mem_we = 0; one cycle later disp_word_valid = 1 and disp_word = RAM[400].
- Active line with v_addr = 1023 and h_addr stepping 0..1279 → prefetches at addresses 81841..81919, 79 pulses per line; no fetch at h_addr = 1272 (word 79); all mem_we = 0.
- cpu_req write (addr = 0x00123, wdata = 0xBEEF) asserted exactly at the PREFETCH_SLOT cycle → display wins that cycle; CPU write is issued next cycle (mem_we = 1, mem_addr = 0x00123); cpu_ack follows 1 cycle later; a subsequent CPU read of 0x00123 returns cpu_rdata = 0xBEEF.
- Back-to-back CPU reads held continuously during blanking → one issue every 2 cycles, cpu_ack on alternate cycles, and no duplicate issue of the same request.
- Assert rst in the CPU_WAIT cycle of a read → cpu_ack stays 0 and all outputs are 0 the next cycle; after rst is deasserted with cpu_req still high, the read is reissued and acked normally.
- line_start coincides with cpu_req during blanking → first-word fetch issued first, then the CPU access; disp_word_valid and cpu_ack occur in consecutive cycles.
